// File: rtl/sram_access_arbiter_if.sv
// Requester-side handshake bundle for one port of the SRAM access arbiter.
// The requester drives req/we/addr/wdata; the arbiter returns rdata and a done pulse.
interface sram_access_arbiter_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
) ();
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              done;

   modport master (
      output req,
      output we,
      output addr,
      output wdata,
      input  rdata,
      input  done
   );

   modport slave (
      input  req,
      input  we,
      input  addr,
      input  wdata,
      output rdata,
      output done
   );
endinterface

// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing one async SRAM port between the CPU path (a) and a loader (b),
// sequencing fixed-length OE/WE strobes and returning a one-cycle done pulse per access.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | strobes high; grant a pending request and latch its command
//  ACCESS | WAIT_CYC+1 cycles with OE (read) or WE (write) held low
//  DONE   | strobes high for bus turnaround; done pulse to granted port
module sram_access_arbiter #(
   parameter int ADDR_W   = 20,
   parameter int DATA_W   = 16,
   parameter int WAIT_CYC = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   sram_access_arbiter_if.slave a,
   sram_access_arbiter_if.slave b,
   output logic              busy,
   output logic [ADDR_W-1:0] Mem_ADDR,
   output logic [DATA_W-1:0] Data_to_SRAM,
   input  logic [DATA_W-1:0] Data_from_SRAM,
   output logic              Mem_CE,
   output logic              Mem_UB,
   output logic              Mem_LB,
   output logic              Mem_OE,
   output logic              Mem_WE
);

   localparam int CNT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             op_we;
   logic             op_we_nxt;
   logic             sel_b;
   logic             last_b;
   logic             grant;
   logic             grant_b;
   logic             oe_nxt;
   logic             we_nxt;
   logic             a_done_nxt;
   logic             b_done_nxt;
   logic             capture;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // On a tie the port that did not win last time is granted.
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      grant_b   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (a.req || b.req) begin
               grant     = 1'b1;
               grant_b   = b.req && (!a.req || !last_b);
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt == CNT_LAST) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      op_we_nxt = grant ? (grant_b ? b.we : a.we) : op_we;
   end

   // Strobes and done are computed from the next state so the pins come straight off flops.
   always_comb begin
      oe_nxt     = !((state_nxt == ST_ACCESS) && !op_we_nxt);
      we_nxt     = !((state_nxt == ST_ACCESS) &&  op_we_nxt);
      a_done_nxt = (state_nxt == ST_DONE) && !sel_b;
      b_done_nxt = (state_nxt == ST_DONE) &&  sel_b;
      capture    = (state == ST_ACCESS) && (cnt == CNT_LAST) && !op_we;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt          <= '0;
         op_we        <= 1'b0;
         sel_b        <= 1'b0;
         last_b       <= 1'b1;
         Mem_ADDR     <= '0;
         Data_to_SRAM <= '0;
         Mem_OE       <= 1'b1;
         Mem_WE       <= 1'b1;
         a.done       <= 1'b0;
         b.done       <= 1'b0;
         a.rdata      <= '0;
         b.rdata      <= '0;
      end else begin
         if (grant) begin
            op_we        <= op_we_nxt;
            sel_b        <= grant_b;
            last_b       <= grant_b;
            Mem_ADDR     <= grant_b ? b.addr  : a.addr;
            Data_to_SRAM <= grant_b ? b.wdata : a.wdata;
            cnt          <= '0;
         end else if (state == ST_ACCESS) begin
            cnt <= cnt + 1'b1;
         end
         Mem_OE <= oe_nxt;
         Mem_WE <= we_nxt;
         a.done <= a_done_nxt;
         b.done <= b_done_nxt;
         if (capture) begin
            if (sel_b) begin
               b.rdata <= Data_from_SRAM;
            end else begin
               a.rdata <= Data_from_SRAM;
            end
         end
      end
   end

   assign busy   = (state != ST_IDLE);
   assign Mem_CE = 1'b0;
   assign Mem_UB = 1'b0;
   assign Mem_LB = 1'b0;

   a_strobe_exclusive: assert property (@(posedge Clk) disable iff (Reset)
      (Mem_OE || Mem_WE));

   a_strobe_only_in_access: assert property (@(posedge Clk) disable iff (Reset)
      (state != ST_ACCESS) |-> (Mem_OE && Mem_WE));

   a_done_exclusive: assert property (@(posedge Clk) disable iff (Reset)
      !(a.done && b.done));

endmodule
